// File: rtl/audio_stream_pkg.sv
// Shared types for the audio stream endpoint: stereo frame layout and level sizing.
package audio_stream_pkg;

   localparam int DATA_W = 24;

   typedef struct packed {
      logic signed [DATA_W-1:0] left;
      logic signed [DATA_W-1:0] right;
   } stereo_frame_t;

   // Occupancy counter must hold 0..depth inclusive.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/audio_stream_if.sv
// Avalon-ST style channel bundle between the audio controller, reverb core and endpoint.
interface audio_stream_if #(
   parameter int DATA_W = audio_stream_pkg::DATA_W
);
   logic [DATA_W-1:0] adc_l_data;
   logic              adc_l_valid;
   logic              adc_l_ready;
   logic [DATA_W-1:0] adc_r_data;
   logic              adc_r_valid;
   logic              adc_r_ready;

   logic [DATA_W-1:0] frame_left;
   logic [DATA_W-1:0] frame_right;
   logic              frame_valid;
   logic              frame_ready;

   logic [DATA_W-1:0] proc_left;
   logic [DATA_W-1:0] proc_right;
   logic              proc_valid;
   logic              proc_ready;

   logic [DATA_W-1:0] dac_l_data;
   logic              dac_l_valid;
   logic              dac_l_ready;
   logic [DATA_W-1:0] dac_r_data;
   logic              dac_r_valid;
   logic              dac_r_ready;

   modport master (
      output adc_l_data, adc_l_valid, adc_r_data, adc_r_valid,
      input  adc_l_ready, adc_r_ready,
      input  frame_left, frame_right, frame_valid,
      output frame_ready,
      output proc_left, proc_right, proc_valid,
      input  proc_ready,
      input  dac_l_data, dac_l_valid, dac_r_data, dac_r_valid,
      output dac_l_ready, dac_r_ready
   );

   modport slave (
      input  adc_l_data, adc_l_valid, adc_r_data, adc_r_valid,
      output adc_l_ready, adc_r_ready,
      output frame_left, frame_right, frame_valid,
      input  frame_ready,
      input  proc_left, proc_right, proc_valid,
      output proc_ready,
      output dac_l_data, dac_l_valid, dac_r_data, dac_r_valid,
      input  dac_l_ready, dac_r_ready
   );

endinterface

// File: rtl/stereo_frame_fifo.sv
// Synchronous stereo frame FIFO with a registered head entry and occupancy output.
module stereo_frame_fifo
   import audio_stream_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int LVL_W = level_w(DEPTH),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  stereo_frame_t    wr_data,
   input  logic             rd_en,
   output stereo_frame_t    head,
   output logic             empty,
   output logic             full,
   output logic [LVL_W-1:0] level
);

   stereo_frame_t    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             push;
   logic             pop;
   logic             body_nonempty;
   logic             load_head_direct;

   assign empty         = (count == '0);
   assign full          = (count == LVL_W'(DEPTH));
   assign level         = count;
   assign push          = wr_en & ~full;
   assign pop           = rd_en & ~empty;
   assign body_nonempty = (count > LVL_W'(1));

   // The head register is the oldest entry; mem only holds entries behind it, so an
   // empty FIFO (or one whose only entry is leaving) loads the incoming frame straight into head.
   assign load_head_direct = push & (empty | (pop & ~body_nonempty));

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               count <= count + 1'b1;
               if (!empty) wr_ptr <= wr_ptr + 1'b1;
            end
            2'b01: begin
               count <= count - 1'b1;
               if (body_nonempty) rd_ptr <= rd_ptr + 1'b1;
            end
            2'b11: begin
               if (body_nonempty) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  wr_ptr <= wr_ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
      end else if (load_head_direct) begin
         head <= wr_data;
      end else if (pop & body_nonempty) begin
         head <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (push & ~load_head_direct) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/audio_stream_endpoint.sv
// Fabric-side audio endpoint: pairs ADC L/R into stereo frames, buffers processed
// frames and splits them back onto the DAC channels, with bypass loopback and status.
module audio_stream_endpoint #(
   parameter  int DATA_W     = audio_stream_pkg::DATA_W,
   parameter  int FIFO_DEPTH = 4,
   parameter  int CNT_W      = 16,
   localparam int LVL_W      = audio_stream_pkg::level_w(FIFO_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   audio_stream_if.slave    bus,
   input  logic             bypass,
   input  logic             clear_status,
   output logic [LVL_W-1:0] fifo_level,
   output logic             underrun,
   output logic [CNT_W-1:0] frame_count
);
   import audio_stream_pkg::*;

   logic signed [DATA_W-1:0] hold_l_p0;
   logic signed [DATA_W-1:0] hold_r_p0;
   logic                     vld_l_p0;
   logic                     vld_r_p0;
   logic                     adc_l_fire;
   logic                     adc_r_fire;
   logic                     pair_full;
   logic                     rx_pop;

   stereo_frame_t            fifo_wdata;
   stereo_frame_t            head_p1;
   logic                     fifo_wr;
   logic                     fifo_full;
   logic                     fifo_empty;

   logic                     sent_l_p1;
   logic                     sent_r_p1;
   logic                     dac_l_fire;
   logic                     dac_r_fire;
   logic                     tx_pop;
   logic                     popped_once;
   logic                     underrun_set;

   // RX pairing stage: one holding register per channel, frame forms when both are full.
   assign bus.adc_l_ready = ~vld_l_p0 & ~reset;
   assign bus.adc_r_ready = ~vld_r_p0 & ~reset;
   assign adc_l_fire      = bus.adc_l_valid & bus.adc_l_ready;
   assign adc_r_fire      = bus.adc_r_valid & bus.adc_r_ready;
   assign pair_full       = vld_l_p0 & vld_r_p0;

   assign bus.frame_valid = pair_full & ~bypass;
   assign bus.frame_left  = hold_l_p0;
   assign bus.frame_right = hold_r_p0;
   // The pair leaves through whichever path bypass selects at the moment it pops.
   assign rx_pop          = pair_full & (bypass ? ~fifo_full : bus.frame_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_l_p0  <= 1'b0;
         vld_r_p0  <= 1'b0;
         hold_l_p0 <= '0;
         hold_r_p0 <= '0;
      end else begin
         if (adc_l_fire) begin
            vld_l_p0  <= 1'b1;
            hold_l_p0 <= bus.adc_l_data;
         end else if (rx_pop) begin
            vld_l_p0  <= 1'b0;
         end
         if (adc_r_fire) begin
            vld_r_p0  <= 1'b1;
            hold_r_p0 <= bus.adc_r_data;
         end else if (rx_pop) begin
            vld_r_p0  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)       frame_count <= '0;
      else if (rx_pop) frame_count <= frame_count + 1'b1;
   end

   // TX buffer stage: processed frames, or paired ADC frames in bypass.
   assign bus.proc_ready = ~bypass & ~fifo_full;
   assign fifo_wr        = bypass ? rx_pop : (bus.proc_valid & bus.proc_ready);

   always_comb begin
      fifo_wdata = '0;
      if (bypass) begin
         fifo_wdata.left  = hold_l_p0;
         fifo_wdata.right = hold_r_p0;
      end else begin
         fifo_wdata.left  = bus.proc_left;
         fifo_wdata.right = bus.proc_right;
      end
   end

   stereo_frame_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (tx_pop),
      .head    (head_p1),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (fifo_level)
   );

   // TX split stage: each channel sends the head once; head retires when both have gone.
   assign bus.dac_l_valid = ~fifo_empty & ~sent_l_p1;
   assign bus.dac_r_valid = ~fifo_empty & ~sent_r_p1;
   assign bus.dac_l_data  = head_p1.left;
   assign bus.dac_r_data  = head_p1.right;
   assign dac_l_fire      = bus.dac_l_valid & bus.dac_l_ready;
   assign dac_r_fire      = bus.dac_r_valid & bus.dac_r_ready;
   assign tx_pop          = ~fifo_empty & (sent_l_p1 | dac_l_fire) & (sent_r_p1 | dac_r_fire);

   always_ff @(posedge clk) begin
      if (reset) begin
         sent_l_p1 <= 1'b0;
         sent_r_p1 <= 1'b0;
      end else if (tx_pop) begin
         sent_l_p1 <= 1'b0;
         sent_r_p1 <= 1'b0;
      end else begin
         if (dac_l_fire) sent_l_p1 <= 1'b1;
         if (dac_r_fire) sent_r_p1 <= 1'b1;
      end
   end

   // Underrun is only meaningful once the DAC path has actually started streaming.
   assign underrun_set = popped_once & fifo_empty & (bus.dac_l_ready | bus.dac_r_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         popped_once <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         popped_once <= popped_once | tx_pop;
         if (underrun_set)      underrun <= 1'b1;
         else if (clear_status) underrun <= 1'b0;
      end
   end

endmodule
